pipe_preif: RTL and testbench

//  Pre-fetch stage: generates next fetch PC and issues it on the inst SRAM request channel.

---
 rtl/pipe_preif_pkg.sv | 28 ++
 rtl/pipe_preif_if.sv | 21 ++
 rtl/pipe_preif_pc_redirect_buf.sv | 51 +++++
 rtl/pipe_preif.sv | 85 ++++++++
 tb/tb_pipe_preif.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_preif_pkg.sv
// Shared types and defaults for the pre-fetch (preIF) stage.
package pipe_preif_pkg;

  localparam int          PC_W_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_PEND
  } state_t;

  typedef enum logic [1:0] {
    RC_NONE,
    RC_EX,
    RC_ERTN,
    RC_BR
  } redir_cause_t;

  // Exception entry outranks ertn, which outranks a resolved branch.
  function automatic redir_cause_t sel_cause(input logic ex, input logic ertn, input logic br);
    if (ex)   return RC_EX;
    if (ertn) return RC_ERTN;
    if (br)   return RC_BR;
    return RC_NONE;
  endfunction

endpackage

// File: rtl/pipe_preif_if.sv
// Inst SRAM request channel plus the preIF -> IF valid/allowin handshake.
interface pipe_preif_if #(
  parameter int PC_W = 32
);
  logic            to_allowin;
  logic            to_valid;
  logic [PC_W-1:0] to_pc;
  logic            inst_sram_req;
  logic [PC_W-1:0] inst_sram_addr;
  logic            inst_sram_addr_ok;

  modport master (
    input  to_allowin, inst_sram_addr_ok,
    output to_valid, to_pc, inst_sram_req, inst_sram_addr
  );

  modport slave (
    output to_allowin, inst_sram_addr_ok,
    input  to_valid, to_pc, inst_sram_req, inst_sram_addr
  );
endinterface

// File: rtl/pipe_preif_pc_redirect_buf.sv
// Redirect priority mux and a one-entry buffer that holds a redirect target
// until the fetch that carries it is accepted.
module pipe_preif_pc_redirect_buf
  import pipe_preif_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_wb,
  input  logic [PC_W-1:0] ex_entry,
  input  logic            flush_wb,
  input  logic [PC_W-1:0] era_pc,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            fire,
  output logic            live,
  output logic [PC_W-1:0] live_tgt,
  output logic            redir_vld,
  output logic [PC_W-1:0] redir_pc
);

  redir_cause_t cause;

  assign cause = sel_cause(ex_wb, flush_wb, br_taken);
  assign live  = (cause != RC_NONE);

  // Pick the live redirect target by cause priority.
  always_comb begin
    live_tgt = br_target;
    case (cause)
      RC_EX:   live_tgt = ex_entry;
      RC_ERTN: live_tgt = era_pc;
      default: live_tgt = br_target;
    endcase
  end

  // Hold an unaccepted redirect; a newer one overwrites, an accepted fetch consumes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redir_vld <= 1'b0;
      redir_pc  <= '0;
    end else if (fire) begin
      redir_vld <= 1'b0;
    end else if (live) begin
      redir_vld <= 1'b1;
      redir_pc  <= live_tgt;
    end
  end

endmodule

// File: rtl/pipe_preif.sv
// Pre-fetch stage: forms the next fetch PC, requests it from the inst SRAM
// and hands it to pipe_IF in the same cycle the SRAM accepts it.
module pipe_preif
  import pipe_preif_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             resetn,
  pipe_preif_if.master     bus,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  input  logic             ex_WB,
  input  logic [PC_W-1:0]  ex_entry,
  input  logic             flush_WB,
  input  logic [PC_W-1:0]  era_pc
);

  localparam logic [PC_W-1:0] BOOT_PC = RESET_PC - PC_W'(4);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] nextpc;
  logic            live;
  logic [PC_W-1:0] live_tgt;
  logic            redir_vld;
  logic [PC_W-1:0] redir_pc;
  logic            req;
  logic            fire;

  pipe_preif_pc_redirect_buf #(.PC_W(PC_W)) u_redir (
    .clk       (clk),
    .resetn    (resetn),
    .ex_wb     (ex_WB),
    .ex_entry  (ex_entry),
    .flush_wb  (flush_WB),
    .era_pc    (era_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .fire      (fire),
    .live      (live),
    .live_tgt  (live_tgt),
    .redir_vld (redir_vld),
    .redir_pc  (redir_pc)
  );

  // During the boot bubble the sequential path shows pc_reg itself; the
  // +4 step only applies once fetching is running.
  assign seq_pc = (state == ST_BOOT) ? pc_reg : pc_reg + PC_W'(4);
  assign nextpc = live ? live_tgt : (redir_vld ? redir_pc : seq_pc);

  assign req  = (state != ST_BOOT) && bus.to_allowin;
  assign fire = req && bus.inst_sram_addr_ok;

  assign bus.inst_sram_req  = req;
  assign bus.inst_sram_addr = nextpc;
  assign bus.to_valid       = fire;
  assign bus.to_pc          = nextpc;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_BOOT;
    else         state <= state_nxt;
  end

  // Next state: one boot bubble, then track whether a redirect is outstanding.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (live && !fire) state_nxt = ST_PEND;
      ST_PEND: if (fire)          state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Architectural fetch PC advances only when the SRAM accepts the request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   pc_reg <= BOOT_PC;
    else if (fire) pc_reg <= nextpc;
  end

endmodule

// File: tb/tb_pipe_preif.sv
// Bench for pipe_preif: directed stimulus, a spec-level model checked every
// cycle, and hand-computed literal expectations.
module tb_pipe_preif;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        br_taken, ex_WB, flush_WB;
  logic [31:0] br_target, ex_entry, era_pc;

  pipe_preif_if #(.PC_W(32)) bus ();

  pipe_preif #(.PC_W(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .br_taken  (br_taken),
    .br_target (br_target),
    .ex_WB     (ex_WB),
    .ex_entry  (ex_entry),
    .flush_WB  (flush_WB),
    .era_pc    (era_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: has fetching started, last accepted PC, outstanding redirect.
  bit          m_boot = 1'b0;
  logic [31:0] m_pc   = RST_PC - 32'd4;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt  = '0;

  function automatic bit m_live();
    return ex_WB || flush_WB || br_taken;
  endfunction

  function automatic logic [31:0] m_addr();
    if (ex_WB)    return ex_entry;
    if (flush_WB) return era_pc;
    if (br_taken) return br_target;
    if (m_pend)   return m_tgt;
    return m_boot ? m_pc + 32'd4 : m_pc;
  endfunction

  function automatic bit m_req();
    return m_boot && bus.to_allowin;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_boot = 1'b0;
      m_pc   = RST_PC - 32'd4;
      m_pend = 1'b0;
    end else begin
      if (m_req() && bus.inst_sram_addr_ok) begin
        m_pc   = m_addr();
        m_pend = 1'b0;
      end else if (m_live()) begin
        m_tgt  = m_addr();
        m_pend = 1'b1;
      end
      m_boot = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("m_req",   {31'd0, bus.inst_sram_req}, {31'd0, m_req()});
    chk("m_valid", {31'd0, bus.to_valid}, {31'd0, m_req() && bus.inst_sram_addr_ok});
    chk("m_addr",  bus.inst_sram_addr, m_addr());
    chk("m_to_pc", bus.to_pc, m_addr());
  end

  task automatic cyc(input bit al, input bit ok, input bit br, input logic [31:0] bt,
                     input bit ex, input bit fl);
    @(posedge clk);
    #1;
    bus.to_allowin        = al;
    bus.inst_sram_addr_ok = ok;
    br_taken              = br;
    br_target             = bt;
    ex_WB                 = ex;
    flush_WB              = fl;
    @(negedge clk);
  endtask

  task automatic expect_fetch(input string name, input logic [31:0] addr, input bit vld);
    chk({name, "_addr"},  bus.inst_sram_addr, addr);
    chk({name, "_valid"}, {31'd0, bus.to_valid}, {31'd0, vld});
  endtask

  initial begin
    bus.to_allowin        = 1'b1;
    bus.inst_sram_addr_ok = 1'b1;
    br_taken  = 1'b0;
    br_target = '0;
    ex_WB     = 1'b0;
    flush_WB  = 1'b0;
    ex_entry  = 32'h1c00_8000;
    era_pc    = 32'h1c00_0040;

    repeat (2) @(negedge clk);
    chk("rst_req",   {31'd0, bus.inst_sram_req}, 32'd0);
    chk("rst_valid", {31'd0, bus.to_valid}, 32'd0);
    chk("rst_to_pc", bus.to_pc, 32'h1bff_fffc);

    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("boot_bubble_req", {31'd0, bus.inst_sram_req}, 32'd0);

    // Sequential fetch after reset.
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("seq0", 32'h1c00_0000, 1);
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("seq1", 32'h1c00_0004, 1);
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("seq2", 32'h1c00_0008, 1);
    chk("seq2_to_pc", bus.to_pc, 32'h1c00_0008);

    // Branch accepted in the same cycle.
    cyc(1, 1, 1, 32'h1c00_0100, 0, 0); expect_fetch("br_now", 32'h1c00_0100, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("br_next", 32'h1c00_0104, 1);

    // Branch pulse while addr_ok stays low for three cycles.
    cyc(1, 0, 1, 32'h1c00_0200, 0, 0); expect_fetch("stall0", 32'h1c00_0200, 0);
    chk("stall0_req", {31'd0, bus.inst_sram_req}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0);             expect_fetch("stall1", 32'h1c00_0200, 0);
    cyc(1, 0, 0, 0, 0, 0);             expect_fetch("stall2", 32'h1c00_0200, 0);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("stall_fire", 32'h1c00_0200, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("stall_next", 32'h1c00_0204, 1);

    // Priority: exception over ertn over branch, then ertn over branch.
    cyc(1, 1, 1, 32'h1c00_0080, 1, 1); expect_fetch("prio_ex", 32'h1c00_8000, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("prio_ex_next", 32'h1c00_8004, 1);
    cyc(1, 1, 1, 32'h1c00_0080, 0, 1); expect_fetch("prio_ertn", 32'h1c00_0040, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("prio_ertn_next", 32'h1c00_0044, 1);

    // IF not accepting for two cycles.
    cyc(0, 1, 0, 0, 0, 0); expect_fetch("hold0", 32'h1c00_0048, 0);
    chk("hold0_req", {31'd0, bus.inst_sram_req}, 32'd0);
    cyc(0, 1, 0, 0, 0, 0); expect_fetch("hold1", 32'h1c00_0048, 0);
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("hold_resume", 32'h1c00_0048, 1);

    // Redirect buffered while IF is not accepting.
    cyc(0, 1, 1, 32'h1c00_0400, 0, 0); expect_fetch("buf0", 32'h1c00_0400, 0);
    cyc(0, 1, 0, 0, 0, 0);             expect_fetch("buf1", 32'h1c00_0400, 0);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("buf_fire", 32'h1c00_0400, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("buf_next", 32'h1c00_0404, 1);

    // Newer redirect overwrites the buffered one while addr_ok is low.
    cyc(1, 0, 1, 32'h1c00_0500, 0, 0); expect_fetch("ovr0", 32'h1c00_0500, 0);
    cyc(1, 0, 1, 32'h1c00_0600, 0, 0); expect_fetch("ovr1", 32'h1c00_0600, 0);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("ovr_fire", 32'h1c00_0600, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("ovr_next", 32'h1c00_0604, 1);

    // Misaligned target passes straight through.
    cyc(1, 1, 1, 32'h1c00_0123, 0, 0); expect_fetch("misal", 32'h1c00_0123, 1);
    cyc(1, 1, 0, 0, 0, 0);             expect_fetch("misal_next", 32'h1c00_0127, 1);

    // Reset while a redirect is pending: the redirect is lost.
    cyc(1, 0, 1, 32'h1c00_0700, 0, 0); expect_fetch("pend", 32'h1c00_0700, 0);
    @(posedge clk);
    #1;
    br_taken = 1'b0;
    bus.inst_sram_addr_ok = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rst2_req",   {31'd0, bus.inst_sram_req}, 32'd0);
    chk("rst2_to_pc", bus.to_pc, 32'h1bff_fffc);
    @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst2_bubble_req", {31'd0, bus.inst_sram_req}, 32'd0);
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("restart0", 32'h1c00_0000, 1);
    cyc(1, 1, 0, 0, 0, 0); expect_fetch("restart1", 32'h1c00_0004, 1);

    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
